// File: rtl/gcm_ae_hw_1x4_deadlock_pkg.sv
// Shared constants for the GCM_AE_HW_1x4 deadlock monitor/reporter pair.
// State encoding is also used by monitor-side harnesses, so keep the values fixed.
package gcm_ae_hw_1x4_deadlock_pkg;

    localparam logic [1:0] ST_WATCH  = 2'd0;
    localparam logic [1:0] ST_REPORT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int DEF_NUM_CHAN  = 7;
    localparam int DEF_THRESHOLD = 1024;

    // Persist counter only needs to reach THRESHOLD-1; keep at least one bit.
    function automatic int persist_w(input int threshold);
        return (threshold > 1) ? $clog2(threshold) : 1;
    endfunction

endpackage

// File: rtl/gcm_ae_hw_1x4_deadlock_persist_cnt.sv
// Saturating consecutive-high counter; hit fires on the THRESHOLD-th consecutive
// high sample while enabled and not being zeroed.
module gcm_ae_hw_1x4_deadlock_persist_cnt
    import gcm_ae_hw_1x4_deadlock_pkg::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic sample,
    input  logic zero,
    output logic hit
);

    localparam int CW = persist_w(THRESHOLD);
    localparam logic [CW-1:0] TOP = CW'(THRESHOLD - 1);

    logic [CW-1:0] cnt;

    assign hit = en && sample && !zero && (cnt == TOP);

    // Restart from zero after a hit so a later return to WATCH needs fresh samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || zero || !sample || hit) begin
            cnt <= '0;
        end else if (cnt != TOP) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gcm_ae_hw_1x4_deadlock_reporter.sv
// Qualifies the deadlock monitor's block flag by persistence and hands one
// timestamped report per event to the host over valid/ready.
module gcm_ae_hw_1x4_deadlock_reporter
    import gcm_ae_hw_1x4_deadlock_pkg::*;
#(
    parameter int NUM_CHAN  = DEF_NUM_CHAN,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int TS_W      = 32,
    parameter int CNT_W     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block_in,
    input  logic [NUM_CHAN-1:0] axis_block_sigs,
    input  logic [NUM_CHAN-1:0] inst_idle_sigs,
    input  logic                clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [NUM_CHAN-1:0] report_chan,
    output logic [TS_W-1:0]     report_ts,
    output logic [CNT_W-1:0]    report_count,
    output logic                deadlock
);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [TS_W-1:0] ts;
    logic            hit;

    gcm_ae_hw_1x4_deadlock_persist_cnt #(
        .THRESHOLD (THRESHOLD)
    ) u_persist (
        .clock  (clock),
        .reset  (reset),
        .en     (state == ST_WATCH),
        .sample (block_in),
        .zero   (clear),
        .hit    (hit)
    );

    // clear overrides every transition, including a handshake in REPORT.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ST_WATCH;
        end else begin
            case (state)
                ST_WATCH:  if (hit)          state_nx = ST_REPORT;
                ST_REPORT: if (report_ready) state_nx = ST_HOLD;
                ST_HOLD:   state_nx = ST_HOLD;
                default:   state_nx = ST_WATCH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_WATCH;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    // Payload survives clear so the host can still read the last event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            report_chan  <= '0;
            report_ts    <= '0;
            report_count <= '0;
        end else if (hit) begin
            report_chan <= axis_block_sigs & ~inst_idle_sigs;
            report_ts   <= ts;
            if (report_count != {CNT_W{1'b1}})
                report_count <= report_count + 1'b1;
        end
    end

    assign report_valid = (state == ST_REPORT);
    assign deadlock     = (state == ST_REPORT) || (state == ST_HOLD);

endmodule

// File: tb/tb_gcm_ae_hw_1x4_deadlock_reporter.sv
// Bench for the deadlock reporter: directed scenarios plus random traffic,
// checked against an event-level model of the reporting rules.
module tb_gcm_ae_hw_1x4_deadlock_reporter;

    localparam int TH      = 4;
    localparam int NCH     = 7;
    localparam int CNT_MAX = 65535;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        block_in = 1'b0, clear = 1'b0, report_ready = 1'b0;
    logic [6:0]  axis_block_sigs = '0, inst_idle_sigs = '0;
    logic        report_valid, deadlock;
    logic [6:0]  report_chan;
    logic [31:0] report_ts;
    logic [15:0] report_count;

    logic        block2 = 1'b0, clear2 = 1'b0, ready2 = 1'b0;
    logic [6:0]  axis2 = '0, idle2 = '0;
    logic        valid2, deadlock2;
    logic [6:0]  chan2;
    logic [3:0]  ts2;
    logic [1:0]  count2;

    int checks = 0;
    int errors = 0;

    gcm_ae_hw_1x4_deadlock_reporter #(
        .NUM_CHAN(NCH), .THRESHOLD(TH), .TS_W(32), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .block_in(block_in),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .clear(clear), .report_valid(report_valid), .report_ready(report_ready),
        .report_chan(report_chan), .report_ts(report_ts),
        .report_count(report_count), .deadlock(deadlock)
    );

    gcm_ae_hw_1x4_deadlock_reporter #(
        .NUM_CHAN(NCH), .THRESHOLD(1), .TS_W(4), .CNT_W(2)
    ) dut2 (
        .clock(clock), .reset(reset), .block_in(block2),
        .axis_block_sigs(axis2), .inst_idle_sigs(idle2),
        .clear(clear2), .report_valid(valid2), .report_ready(ready2),
        .report_chan(chan2), .report_ts(ts2),
        .report_count(count2), .deadlock(deadlock2)
    );

    always #5 clock = ~clock;

    // Event-level model: phase 0 = watching, 1 = report pending, 2 = report taken.
    int          m_phase, m_run;
    logic [31:0] m_ts, m_rts;
    logic [6:0]  m_chan;
    logic [15:0] m_cnt;
    logic [3:0]  m2_ts;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_run <= 0; m_ts <= '0; m_rts <= '0; m_chan <= '0; m_cnt <= '0;
        end else begin
            m_ts <= m_ts + 32'd1;
            if (clear) begin
                m_phase <= 0; m_run <= 0;
            end else if (m_phase == 0) begin
                if (!block_in) m_run <= 0;
                else if (m_run + 1 >= TH) begin
                    m_phase <= 1; m_run <= 0;
                    m_chan <= axis_block_sigs & ~inst_idle_sigs;
                    m_rts  <= m_ts;
                    if (int'(m_cnt) < CNT_MAX) m_cnt <= m_cnt + 16'd1;
                end else m_run <= m_run + 1;
            end else if (m_phase == 1 && report_ready) begin
                m_phase <= 2;
            end
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) m2_ts <= '0;
        else       m2_ts <= m2_ts + 4'd1;
    end

    logic [56:0] dut_bus, exp_bus;
    assign dut_bus = {report_valid, deadlock, report_chan, report_ts, report_count};
    assign exp_bus = {m_phase == 1, m_phase != 0, m_chan, m_rts, m_cnt};

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_bus !== 57'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", dut_bus);
        end
        checks++;
        if ({valid2, deadlock2, chan2, ts2, count2} !== 15'd0) begin
            errors++; $display("FAIL reset_outputs2: got %h want 0", {valid2, deadlock2, chan2, ts2, count2});
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_short_bursts();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                block_in = (c < 3);
                axis_block_sigs = 7'($urandom);
                step();
                checks++;
                if (report_valid !== 1'b0 || report_count !== 16'd0) begin
                    errors++; $display("FAIL short_burst: got valid %b count %0d want 0 0", report_valid, report_count);
                end
            end
        end
        block_in = 1'b0;
    endtask

    task automatic test_detect();
        do_reset();
        for (int i = 0; i < 300 && m_ts != 32'd97; i++) step();
        checks++;
        if (m_ts != 32'd97) begin
            errors++; $display("FAIL detect_align: got ts %0d want 97", m_ts);
        end
        block_in = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin axis_block_sigs = 7'h41; inst_idle_sigs = 7'h01; end
            step();
            checks++;
            if (report_valid !== (c == 4)) begin
                errors++; $display("FAIL detect_timing: cycle %0d got %b want %b", c, report_valid, c == 4);
            end
        end
        block_in = 1'b0;
        checks++;
        if ({report_valid, deadlock, report_chan, report_ts, report_count} !== {1'b1, 1'b1, 7'h40, 32'd100, 16'd1}) begin
            errors++; $display("FAIL detect_payload: got %h want %h", dut_bus, {1'b1, 1'b1, 7'h40, 32'd100, 16'd1});
        end
    endtask

    task automatic test_hold_stable();
        for (int i = 0; i < 10; i++) begin
            axis_block_sigs = 7'($urandom);
            inst_idle_sigs  = 7'($urandom);
            block_in        = 1'($urandom);
            step();
            checks++;
            if ({report_valid, report_chan, report_ts, report_count} !== {1'b1, 7'h40, 32'd100, 16'd1}) begin
                errors++; $display("FAIL report_stable: got %h want %h", {report_valid, report_chan, report_ts, report_count}, {1'b1, 7'h40, 32'd100, 16'd1});
            end
        end
        block_in = 1'b0;
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        checks++;
        if ({report_valid, deadlock} !== 2'b01) begin
            errors++; $display("FAIL hold_state: got %b want 01", {report_valid, deadlock});
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({deadlock, report_chan, report_ts, report_count} !== {1'b0, 7'h40, 32'd100, 16'd1}) begin
            errors++; $display("FAIL clear_hold: got %h want %h", {deadlock, report_chan, report_ts, report_count}, {1'b0, 7'h40, 32'd100, 16'd1});
        end
    endtask

    task automatic test_clear_vs_ready();
        block_in = 1'b1;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if ({report_valid, report_count} !== {1'b1, 16'd2}) begin
            errors++; $display("FAIL second_report: got %h want %h", {report_valid, report_count}, {1'b1, 16'd2});
        end
        clear = 1'b1; report_ready = 1'b1;
        step();
        clear = 1'b0; report_ready = 1'b0;
        checks++;
        if ({report_valid, deadlock, report_count} !== {2'b00, 16'd2}) begin
            errors++; $display("FAIL clear_wins: got %h want %h", {report_valid, deadlock, report_count}, {2'b00, 16'd2});
        end
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (report_valid !== (c == 4) || dut_bus !== exp_bus) begin
                errors++; $display("FAIL rearm_report: cycle %0d got %h want %h", c, dut_bus, exp_bus);
            end
        end
        checks++;
        if (report_count !== 16'd3) begin
            errors++; $display("FAIL rearm_count: got %0d want 3", report_count);
        end
        block_in = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_mid_reset();
        block_in = 1'b1;
        for (int c = 0; c < 3; c++) step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_bus !== 57'd0 || {valid2, deadlock2} !== 2'b00) begin
            errors++; $display("FAIL async_reset: got %h want 0", dut_bus);
        end
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (report_valid !== (c == 4) || dut_bus !== exp_bus) begin
                errors++; $display("FAIL post_reset: cycle %0d got %h want %h", c, dut_bus, exp_bus);
            end
        end
        block_in = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            block_in        = (($urandom % 8) != 0);
            axis_block_sigs = 7'($urandom);
            inst_idle_sigs  = 7'($urandom);
            report_ready    = (($urandom % 4) == 0);
            clear           = (($urandom % 64) == 0);
            step();
            checks++;
            if (dut_bus !== exp_bus) begin
                errors++; $display("FAIL random: cycle %0d got %h want %h", i, dut_bus, exp_bus);
            end
        end
        block_in = 1'b0; report_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic test_saturate_wrap();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            block2 = 1'b1;
            axis2  = 7'($urandom);
            step();
            block2 = 1'b0;
            checks++;
            if ({valid2, chan2, count2} !== {1'b1, axis2, 2'((k > 3) ? 3 : k)}) begin
                errors++; $display("FAIL saturate: pulse %0d got %h want %h", k, {valid2, chan2, count2}, {1'b1, axis2, 2'((k > 3) ? 3 : k)});
            end
            clear2 = 1'b1;
            step();
            clear2 = 1'b0;
            checks++;
            if ({valid2, deadlock2} !== 2'b00) begin
                errors++; $display("FAIL saturate_clear: got %b want 00", {valid2, deadlock2});
            end
        end
        for (int i = 0; i < 40 && m2_ts != 4'd15; i++) step();
        block2 = 1'b1;
        step();
        block2 = 1'b0;
        checks++;
        if ({valid2, ts2, count2} !== {1'b1, 4'd15, 2'd3}) begin
            errors++; $display("FAIL ts_15: got %h want %h", {valid2, ts2, count2}, {1'b1, 4'd15, 2'd3});
        end
        clear2 = 1'b1;
        step();
        clear2 = 1'b0;
        for (int i = 0; i < 40 && m2_ts != 4'd0; i++) step();
        block2 = 1'b1;
        step();
        block2 = 1'b0;
        checks++;
        if ({valid2, ts2, count2} !== {1'b1, 4'd0, 2'd3}) begin
            errors++; $display("FAIL ts_wrap: got %h want %h", {valid2, ts2, count2}, {1'b1, 4'd0, 2'd3});
        end
    endtask

    initial begin
        test_reset();
        test_short_bursts();
        test_detect();
        test_hold_stable();
        test_clear_vs_ready();
        test_mid_reset();
        test_random();
        test_saturate_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
